// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
// Shares the core's single 32-bit AXI4 master port between the instruction
// cache (read-only) and the data cache (reads plus write-backs). Reads and
// writes are handled by independent state machines, so one read burst and one
// write burst can be outstanding together. Reads are granted round-robin, and
// data-cache reads are held off while a write is outstanding so a read can
// never overtake an earlier write-back to the same line.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   ireq_* / irsp_*            I-cache read request handshake and returned beats
//   dreq_* / drsp_*            D-cache read request handshake and returned beats
//   dw_valid/ready/addr/len/size     D-cache write-back request
//   dw_data_valid/ready/data/strb    D-cache write-back data beats
//   dw_done, dw_err            one-cycle write completion, error = b_resp[1]
//   ar_*, r_*, aw_*, w_*, b_*  AXI4 master channels toward mem_bus
module axi_mem_arbiter #(
    parameter logic [3:0] ICACHE_ID = 4'd0,
    parameter logic [3:0] DCACHE_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    // I-cache read port
    input  logic        ireq_valid,
    output logic        ireq_ready,
    input  logic [31:0] ireq_addr,
    input  logic [7:0]  ireq_len,
    output logic        irsp_valid,
    output logic        irsp_last,
    output logic [31:0] irsp_data,
    // D-cache read port
    input  logic        dreq_valid,
    output logic        dreq_ready,
    input  logic [31:0] dreq_addr,
    input  logic [7:0]  dreq_len,
    input  logic [2:0]  dreq_size,
    output logic        drsp_valid,
    output logic        drsp_last,
    output logic [31:0] drsp_data,
    // D-cache write-back port
    input  logic        dw_valid,
    output logic        dw_ready,
    input  logic [31:0] dw_addr,
    input  logic [7:0]  dw_len,
    input  logic [2:0]  dw_size,
    input  logic        dw_data_valid,
    output logic        dw_data_ready,
    input  logic [31:0] dw_data,
    input  logic [3:0]  dw_strb,
    output logic        dw_done,
    output logic        dw_err,
    // AXI read address channel
    output logic [3:0]  ar_id,
    output logic [31:0] ar_addr,
    output logic [7:0]  ar_len,
    output logic [2:0]  ar_size,
    output logic [1:0]  ar_burst,
    output logic [1:0]  ar_lock,
    output logic [3:0]  ar_cache,
    output logic [2:0]  ar_prot,
    output logic        ar_valid,
    input  logic        ar_ready,
    // AXI read data channel
    input  logic [3:0]  r_id,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    input  logic        r_last,
    input  logic        r_valid,
    output logic        r_ready,
    // AXI write address channel
    output logic [3:0]  aw_id,
    output logic [31:0] aw_addr,
    output logic [7:0]  aw_len,
    output logic [2:0]  aw_size,
    output logic [1:0]  aw_burst,
    output logic [1:0]  aw_lock,
    output logic [3:0]  aw_cache,
    output logic [2:0]  aw_prot,
    output logic        aw_valid,
    input  logic        aw_ready,
    // AXI write data channel
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    output logic        w_last,
    output logic        w_valid,
    input  logic        w_ready,
    // AXI write response channel
    input  logic [3:0]  b_id,
    input  logic [1:0]  b_resp,
    input  logic        b_valid,
    output logic        b_ready
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

    r_state_e    r_state_q, r_state_d;
    logic        owner_q, owner_d;            // 1 = D-cache owns the current read
    logic        last_grant_q, last_grant_d;  // 1 = D-cache won the previous grant
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [7:0]  ar_len_q, ar_len_d;
    logic [2:0]  ar_size_q, ar_size_d;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [7:0]  aw_len_q, aw_len_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;

    logic        grant_i, grant_d;
    logic        r_fire, w_fire;

    // Response IDs and the low response bit carry nothing this block acts on.
    logic        unused_inputs;
    assign unused_inputs = ^{r_id, r_resp, b_id, b_resp[0]};

    // Grant decision. Readies are masked by rst_n so a requester never sees a
    // completed handshake while the block is held in reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst_n && r_state_q == R_IDLE) begin
            if (ireq_valid && dreq_valid && w_state_q == W_IDLE) begin
                grant_d = !last_grant_q;
                grant_i = last_grant_q;
            end else begin
                grant_i = ireq_valid;
                grant_d = dreq_valid && (w_state_q == W_IDLE);
            end
        end
    end

    assign r_fire = (r_state_q == R_DATA) && r_valid;
    assign w_fire = (w_state_q == W_DATA) && dw_data_valid && w_ready;

    // Read channel next state: capture the winner's request, then walk AR and R.
    always_comb begin
        r_state_d    = r_state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ar_addr_d    = ar_addr_q;
        ar_len_d     = ar_len_q;
        ar_size_d    = ar_size_q;
        case (r_state_q)
            R_IDLE: begin
                if (grant_i || grant_d) begin
                    r_state_d    = R_ADDR;
                    owner_d      = grant_d;
                    last_grant_d = grant_d;
                    ar_addr_d    = grant_d ? dreq_addr : ireq_addr;
                    ar_len_d     = grant_d ? dreq_len  : ireq_len;
                    ar_size_d    = grant_d ? dreq_size : 3'b010;
                end
            end
            R_ADDR: if (ar_ready) r_state_d = R_DATA;
            R_DATA: if (r_valid && r_last) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write channel next state: the beat counter restarts with every new request.
    always_comb begin
        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        beat_cnt_d = beat_cnt_q;
        case (w_state_q)
            W_IDLE: begin
                if (dw_valid) begin
                    w_state_d  = W_ADDR;
                    aw_addr_d  = dw_addr;
                    aw_len_d   = dw_len;
                    aw_size_d  = dw_size;
                    beat_cnt_d = 8'd0;
                end
            end
            W_ADDR: if (aw_ready) w_state_d = W_DATA;
            W_DATA: begin
                if (w_fire) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == aw_len_q) w_state_d = W_RESP;
                end
            end
            W_RESP: if (b_valid) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // All state, both channels; reset leaves the I-cache as last winner so the
    // D-cache takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= R_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            ar_addr_q    <= 32'd0;
            ar_len_q     <= 8'd0;
            ar_size_q    <= 3'd0;
            w_state_q    <= W_IDLE;
            aw_addr_q    <= 32'd0;
            aw_len_q     <= 8'd0;
            aw_size_q    <= 3'd0;
            beat_cnt_q   <= 8'd0;
        end else begin
            r_state_q    <= r_state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ar_addr_q    <= ar_addr_d;
            ar_len_q     <= ar_len_d;
            ar_size_q    <= ar_size_d;
            w_state_q    <= w_state_d;
            aw_addr_q    <= aw_addr_d;
            aw_len_q     <= aw_len_d;
            aw_size_q    <= aw_size_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Read-side outputs
    assign ireq_ready = grant_i;
    assign dreq_ready = grant_d;
    assign ar_valid   = (r_state_q == R_ADDR);
    assign ar_id      = owner_q ? DCACHE_ID : ICACHE_ID;
    assign ar_addr    = ar_addr_q;
    assign ar_len     = ar_len_q;
    assign ar_size    = ar_size_q;
    assign ar_burst   = 2'b01;
    assign ar_lock    = 2'b00;
    assign ar_cache   = 4'd0;
    assign ar_prot    = 3'd0;
    assign r_ready    = (r_state_q == R_DATA);
    assign irsp_valid = r_fire && !owner_q;
    assign irsp_last  = r_fire && !owner_q && r_last;
    assign irsp_data  = r_data;
    assign drsp_valid = r_fire && owner_q;
    assign drsp_last  = r_fire && owner_q && r_last;
    assign drsp_data  = r_data;

    // Write-side outputs
    assign dw_ready      = rst_n && (w_state_q == W_IDLE) && dw_valid;
    assign aw_valid      = (w_state_q == W_ADDR);
    assign aw_id         = DCACHE_ID;
    assign aw_addr       = aw_addr_q;
    assign aw_len        = aw_len_q;
    assign aw_size       = aw_size_q;
    assign aw_burst      = 2'b01;
    assign aw_lock       = 2'b00;
    assign aw_cache      = 4'd0;
    assign aw_prot       = 3'd0;
    assign w_valid       = (w_state_q == W_DATA) && dw_data_valid;
    assign dw_data_ready = (w_state_q == W_DATA) && w_ready;
    assign w_data        = dw_data;
    assign w_strb        = dw_strb;
    assign w_last        = (w_state_q == W_DATA) && (beat_cnt_q == aw_len_q);
    assign b_ready       = (w_state_q == W_RESP);
    assign dw_done       = (w_state_q == W_RESP) && b_valid;
    assign dw_err        = (w_state_q == W_RESP) && b_valid && b_resp[1];

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Self-checking bench for axi_mem_arbiter. Inputs change 1 ns after the rising
// edge and outputs are sampled on the falling edge. The reference model tracks
// who won the last read grant and derives every expected value from the
// arbitration and channel rules with random addresses, data and lengths.
`timescale 1ns/1ps
module tb_axi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq_valid, ireq_ready, irsp_valid, irsp_last;
    logic [31:0] ireq_addr, irsp_data;
    logic [7:0]  ireq_len;
    logic        dreq_valid, dreq_ready, drsp_valid, drsp_last;
    logic [31:0] dreq_addr, drsp_data;
    logic [7:0]  dreq_len;
    logic [2:0]  dreq_size;
    logic        dw_valid, dw_ready, dw_data_valid, dw_data_ready, dw_done, dw_err;
    logic [31:0] dw_addr, dw_data;
    logic [7:0]  dw_len;
    logic [2:0]  dw_size;
    logic [3:0]  dw_strb;
    logic [3:0]  ar_id, ar_cache, aw_id, aw_cache, r_id, b_id, w_strb;
    logic [31:0] ar_addr, aw_addr, r_data, w_data;
    logic [7:0]  ar_len, aw_len;
    logic [2:0]  ar_size, ar_prot, aw_size, aw_prot;
    logic [1:0]  ar_burst, ar_lock, aw_burst, aw_lock, r_resp, b_resp;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;

    int errors = 0;
    int checks = 0;
    bit model_last_d;   // reference: D-cache won the most recent read grant

    always #5 clk = ~clk;

    axi_mem_arbiter #(.ICACHE_ID(4'd0), .DCACHE_ID(4'd1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr), .ireq_len(ireq_len),
        .irsp_valid(irsp_valid), .irsp_last(irsp_last), .irsp_data(irsp_data),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr), .dreq_len(dreq_len),
        .dreq_size(dreq_size), .drsp_valid(drsp_valid), .drsp_last(drsp_last), .drsp_data(drsp_data),
        .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr), .dw_len(dw_len), .dw_size(dw_size),
        .dw_data_valid(dw_data_valid), .dw_data_ready(dw_data_ready), .dw_data(dw_data), .dw_strb(dw_strb),
        .dw_done(dw_done), .dw_err(dw_err),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ireq_valid = 0; ireq_addr = 0; ireq_len = 0;
        dreq_valid = 0; dreq_addr = 0; dreq_len = 0; dreq_size = 0;
        dw_valid = 0; dw_addr = 0; dw_len = 0; dw_size = 0;
        dw_data_valid = 0; dw_data = 0; dw_strb = 0;
        ar_ready = 0; r_id = 0; r_data = 0; r_resp = 0; r_last = 0; r_valid = 0;
        aw_ready = 0; w_ready = 0; b_id = 0; b_resp = 0; b_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        #1 rst_n = 1'b0;
        ireq_valid = 1; dreq_valid = 1; dw_valid = 1; dw_data_valid = 1; w_ready = 1;
        sample();
        checks++; if (ireq_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ireq_ready got=%0b exp=0", ireq_ready); end
        checks++; if (dreq_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_dreq_ready got=%0b exp=0", dreq_ready); end
        checks++; if (dw_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_dw_ready got=%0b exp=0", dw_ready); end
        checks++; if (dw_data_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_dw_data_ready got=%0b exp=0", dw_data_ready); end
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_ar_valid got=%0b exp=0", ar_valid); end
        checks++; if (r_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_r_ready got=%0b exp=0", r_ready); end
        checks++; if (aw_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_aw_valid got=%0b exp=0", aw_valid); end
        checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_w_valid got=%0b exp=0", w_valid); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_ready got=%0b exp=0", b_ready); end
        checks++; if (dw_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_dw_done got=%0b exp=0", dw_done); end
        checks++; if ({irsp_valid, drsp_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rst_rsp_valid got=%b exp=00", {irsp_valid, drsp_valid}); end
        checks++; if (ar_addr !== 32'd0 || ar_len !== 8'd0 || ar_size !== 3'd0) begin errors++; $display("[TB] FAIL rst_ar_fields got=%h/%h/%h exp=0/0/0", ar_addr, ar_len, ar_size); end
        @(posedge clk);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        model_last_d = 1'b0;
        sample();
        checks++; if (ar_valid !== 1'b0 || aw_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_idle got=%b exp=00", {ar_valid, aw_valid}); end
        next_cycle();
    endtask

    task automatic test_single_iread();
        int beats;
        int cyc;
        ireq_valid = 1; ireq_addr = 32'h1C00_0000; ireq_len = 8'd3;
        sample();
        checks++; if (ireq_ready !== 1'b1) begin errors++; $display("[TB] FAIL t1_ireq_ready got=%0b exp=1", ireq_ready); end
        checks++; if (dreq_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_dreq_ready got=%0b exp=0", dreq_ready); end
        model_last_d = 1'b0;
        next_cycle();
        ireq_valid = 0; ireq_addr = $urandom(); ireq_len = 8'($urandom());
        sample();
        checks++; if (ar_valid !== 1'b1) begin errors++; $display("[TB] FAIL t1_ar_valid got=%0b exp=1", ar_valid); end
        checks++; if (ar_id !== 4'd0) begin errors++; $display("[TB] FAIL t1_ar_id got=%0d exp=0", ar_id); end
        checks++; if (ar_addr !== 32'h1C00_0000) begin errors++; $display("[TB] FAIL t1_ar_addr got=%h exp=1c000000", ar_addr); end
        checks++; if (ar_len !== 8'd3 || ar_size !== 3'd2) begin errors++; $display("[TB] FAIL t1_ar_len_size got=%0d/%0d exp=3/2", ar_len, ar_size); end
        checks++; if ({ar_burst, ar_lock, ar_cache, ar_prot} !== {2'b01, 9'd0}) begin errors++; $display("[TB] FAIL t1_ar_fixed got=%b exp=01_000000000", {ar_burst, ar_lock, ar_cache, ar_prot}); end
        checks++; if (r_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_r_ready_early got=%0b exp=0", r_ready); end
        ar_ready = 1;
        next_cycle();
        ar_ready = 0;
        beats = 0;
        cyc = 0;
        while (beats < 4 && cyc < 40) begin
            r_valid = 1'($urandom_range(0, 1));
            r_data = $urandom(); r_id = 4'($urandom()); r_resp = 2'($urandom());
            r_last = (beats == 3);
            sample();
            checks++; if (r_ready !== 1'b1) begin errors++; $display("[TB] FAIL t1_r_ready got=%0b exp=1", r_ready); end
            checks++; if (irsp_valid !== r_valid || drsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL t1_rsp_valid got=%b exp=%b0", {irsp_valid, drsp_valid}, r_valid); end
            checks++; if (irsp_last !== (r_valid && beats == 3)) begin errors++; $display("[TB] FAIL t1_irsp_last got=%0b exp=%0b", irsp_last, r_valid && beats == 3); end
            if (r_valid) begin
                checks++; if (irsp_data !== r_data) begin errors++; $display("[TB] FAIL t1_irsp_data got=%h exp=%h", irsp_data, r_data); end
                beats++;
            end
            next_cycle();
            cyc++;
        end
        r_valid = 0; r_last = 0;
        sample();
        checks++; if (r_ready !== 1'b0 || ar_valid !== 1'b0) begin errors++; $display("[TB] FAIL t1_back_idle got=%b exp=00", {r_ready, ar_valid}); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        bit want_i, want_d, win_d;
        logic [31:0] ia, da, rd;
        logic [2:0] dsz;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) begin
                want_i = 1; want_d = 1;
            end else begin
                case ($urandom_range(0, 2))
                    0: begin want_i = 1; want_d = 1; end
                    1: begin want_i = 1; want_d = 0; end
                    default: begin want_i = 0; want_d = 1; end
                endcase
            end
            win_d = (want_i && want_d) ? !model_last_d : want_d;
            ia = $urandom(); da = $urandom(); dsz = 3'($urandom_range(0, 2));
            ireq_valid = want_i; dreq_valid = want_d;
            ireq_addr = ia; dreq_addr = da; ireq_len = 0; dreq_len = 0; dreq_size = dsz;
            sample();
            checks++; if ({ireq_ready, dreq_ready} !== {!win_d, win_d}) begin errors++; $display("[TB] FAIL rr_grant k=%0d got=%b exp=%b", k, {ireq_ready, dreq_ready}, {!win_d, win_d}); end
            model_last_d = win_d;
            next_cycle();
            ireq_addr = $urandom(); dreq_addr = $urandom();
            sample();
            checks++; if (ar_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_ar_valid k=%0d got=%0b exp=1", k, ar_valid); end
            checks++; if (ar_addr !== (win_d ? da : ia)) begin errors++; $display("[TB] FAIL rr_ar_addr k=%0d got=%h exp=%h", k, ar_addr, win_d ? da : ia); end
            checks++; if (ar_id !== (win_d ? 4'd1 : 4'd0) || ar_size !== (win_d ? dsz : 3'd2)) begin errors++; $display("[TB] FAIL rr_ar_id_size k=%0d got=%0d/%0d", k, ar_id, ar_size); end
            checks++; if ({ireq_ready, dreq_ready} !== 2'b00) begin errors++; $display("[TB] FAIL rr_busy_ready k=%0d got=%b exp=00", k, {ireq_ready, dreq_ready}); end
            ar_ready = 1;
            next_cycle();
            ar_ready = 0; rd = $urandom(); r_valid = 1; r_last = 1; r_data = rd;
            sample();
            checks++; if ({irsp_valid, drsp_valid} !== {!win_d, win_d}) begin errors++; $display("[TB] FAIL rr_rsp_route k=%0d got=%b exp=%b", k, {irsp_valid, drsp_valid}, {!win_d, win_d}); end
            checks++; if ((win_d ? drsp_data : irsp_data) !== rd || (win_d ? drsp_last : irsp_last) !== 1'b1) begin errors++; $display("[TB] FAIL rr_rsp_data k=%0d got=%h exp=%h", k, win_d ? drsp_data : irsp_data, rd); end
            next_cycle();
            r_valid = 0; r_last = 0;
        end
        ireq_valid = 0; dreq_valid = 0;
    endtask

    task automatic test_write_burst();
        logic [31:0] wd [8];
        logic [3:0]  ws [8];
        logic [31:0] wa;
        int beat;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom(); ws[i] = 4'($urandom());
        end
        wa = $urandom() & 32'hFFFF_FFE0;
        dw_valid = 1; dw_addr = wa; dw_len = 8'd7; dw_size = 3'b010;
        sample();
        checks++; if (dw_ready !== 1'b1) begin errors++; $display("[TB] FAIL wr_dw_ready got=%0b exp=1", dw_ready); end
        next_cycle();
        dw_valid = 0; dw_addr = $urandom(); dw_len = 8'($urandom());
        dw_data_valid = 1; dw_data = wd[0]; dw_strb = ws[0]; w_ready = 1;
        sample();
        checks++; if (aw_valid !== 1'b1 || aw_addr !== wa || aw_len !== 8'd7) begin errors++; $display("[TB] FAIL wr_aw got=%0b/%h/%0d exp=1/%h/7", aw_valid, aw_addr, aw_len, wa); end
        checks++; if (aw_id !== 4'd1 || aw_size !== 3'd2 || {aw_burst, aw_lock, aw_cache, aw_prot} !== {2'b01, 9'd0}) begin errors++; $display("[TB] FAIL wr_aw_fields got=%0d/%0d/%b", aw_id, aw_size, {aw_burst, aw_lock, aw_cache, aw_prot}); end
        checks++; if (w_valid !== 1'b0 || dw_data_ready !== 1'b0) begin errors++; $display("[TB] FAIL wr_w_before_aw got=%b exp=00", {w_valid, dw_data_ready}); end
        aw_ready = 1;
        next_cycle();
        aw_ready = 0;
        beat = 0;
        cyc = 0;
        while (beat < 8 && cyc < 40) begin
            w_ready = (cyc % 2 == 0);
            dw_data_valid = 1; dw_data = wd[beat]; dw_strb = ws[beat];
            sample();
            checks++; if (w_valid !== 1'b1 || w_data !== wd[beat] || w_strb !== ws[beat]) begin errors++; $display("[TB] FAIL wr_w_beat%0d got=%0b/%h/%h exp=1/%h/%h", beat, w_valid, w_data, w_strb, wd[beat], ws[beat]); end
            checks++; if (w_last !== (beat == 7)) begin errors++; $display("[TB] FAIL wr_w_last beat=%0d got=%0b exp=%0b", beat, w_last, beat == 7); end
            checks++; if (dw_data_ready !== w_ready || b_ready !== 1'b0) begin errors++; $display("[TB] FAIL wr_ready_pass got=%b exp=%b0", {dw_data_ready, b_ready}, w_ready); end
            if (w_ready) beat++;
            next_cycle();
            cyc++;
        end
        dw_data_valid = 0; w_ready = 0;
        sample();
        checks++; if (b_ready !== 1'b1 || dw_done !== 1'b0 || w_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_resp_wait got=%b exp=100", {b_ready, dw_done, w_valid}); end
        next_cycle();
        b_valid = 1; b_resp = 2'b10; b_id = 4'd1;
        sample();
        checks++; if (dw_done !== 1'b1 || dw_err !== 1'b1) begin errors++; $display("[TB] FAIL wr_done_err got=%b exp=11", {dw_done, dw_err}); end
        next_cycle();
        b_valid = 0; b_resp = 0;
        sample();
        checks++; if (dw_done !== 1'b0 || b_ready !== 1'b0 || aw_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_after_done got=%b exp=000", {dw_done, b_ready, aw_valid}); end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        logic [31:0] wa, da, rd, wdat;
        wa = $urandom(); da = $urandom(); rd = $urandom(); wdat = $urandom();
        dw_valid = 1; dw_addr = wa; dw_len = 0; dw_size = 3'd2;
        dreq_valid = 1; dreq_addr = da; dreq_len = 0; dreq_size = 3'd2;
        sample();
        checks++; if ({dw_ready, dreq_ready} !== 2'b11) begin errors++; $display("[TB] FAIL sim_both_ready got=%b exp=11", {dw_ready, dreq_ready}); end
        model_last_d = 1'b1;
        next_cycle();
        dw_valid = 0; dreq_addr = $urandom();
        sample();
        checks++; if (dreq_ready !== 1'b0) begin errors++; $display("[TB] FAIL sim_dreq_busy got=%0b exp=0", dreq_ready); end
        checks++; if (ar_valid !== 1'b1 || ar_addr !== da || ar_id !== 4'd1) begin errors++; $display("[TB] FAIL sim_ar got=%0b/%h/%0d exp=1/%h/1", ar_valid, ar_addr, ar_id, da); end
        checks++; if (aw_valid !== 1'b1 || aw_addr !== wa) begin errors++; $display("[TB] FAIL sim_aw got=%0b/%h exp=1/%h", aw_valid, aw_addr, wa); end
        ar_ready = 1; aw_ready = 1;
        next_cycle();
        ar_ready = 0; aw_ready = 0;
        r_valid = 1; r_last = 1; r_data = rd;
        dw_data_valid = 1; dw_data = wdat; dw_strb = 4'hF; w_ready = 1;
        sample();
        checks++; if (drsp_valid !== 1'b1 || drsp_data !== rd || irsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL sim_drsp got=%0b/%h/%0b exp=1/%h/0", drsp_valid, drsp_data, irsp_valid, rd); end
        checks++; if (w_valid !== 1'b1 || w_last !== 1'b1 || w_data !== wdat) begin errors++; $display("[TB] FAIL sim_w got=%0b/%0b/%h exp=1/1/%h", w_valid, w_last, w_data, wdat); end
        next_cycle();
        r_valid = 0; r_last = 0; dw_data_valid = 0; w_ready = 0;
        b_valid = 1; b_resp = 2'b00;
        sample();
        checks++; if (dw_done !== 1'b1 || dw_err !== 1'b0) begin errors++; $display("[TB] FAIL sim_done got=%b exp=10", {dw_done, dw_err}); end
        checks++; if (dreq_ready !== 1'b0) begin errors++; $display("[TB] FAIL sim_dreq_during_resp got=%0b exp=0", dreq_ready); end
        next_cycle();
        b_valid = 0;
        sample();
        checks++; if (dreq_ready !== 1'b1) begin errors++; $display("[TB] FAIL sim_dreq_after_b got=%0b exp=1", dreq_ready); end
        model_last_d = 1'b1;
        next_cycle();
        dreq_valid = 0;
        ar_ready = 1;
        next_cycle();
        ar_ready = 0; r_valid = 1; r_last = 1; r_data = rd ^ 32'hA5A5_A5A5;
        sample();
        checks++; if (drsp_valid !== 1'b1 || drsp_last !== 1'b1) begin errors++; $display("[TB] FAIL sim_second_drsp got=%b exp=11", {drsp_valid, drsp_last}); end
        next_cycle();
        r_valid = 0; r_last = 0;
    endtask

    task automatic test_raw_block();
        logic [31:0] ia;
        ia = $urandom();
        dw_valid = 1; dw_addr = $urandom(); dw_len = 8'd1; dw_size = 3'd2;
        sample();
        checks++; if (dw_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_dw_ready got=%0b exp=1", dw_ready); end
        next_cycle();
        dw_valid = 0; aw_ready = 1;
        next_cycle();
        aw_ready = 0;
        dreq_valid = 1; dreq_addr = $urandom(); dreq_len = 0; dreq_size = 3'd2;
        ireq_valid = 1; ireq_addr = ia; ireq_len = 0;
        sample();
        checks++; if ({ireq_ready, dreq_ready} !== 2'b10) begin errors++; $display("[TB] FAIL raw_iread_only got=%b exp=10", {ireq_ready, dreq_ready}); end
        model_last_d = 1'b0;
        next_cycle();
        ireq_valid = 0;
        sample();
        checks++; if (ar_valid !== 1'b1 || ar_id !== 4'd0 || ar_addr !== ia || dreq_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_ar got=%0b/%0d/%h/%0b exp=1/0/%h/0", ar_valid, ar_id, ar_addr, dreq_ready, ia); end
        ar_ready = 1;
        next_cycle();
        ar_ready = 0; r_valid = 1; r_last = 1; r_data = $urandom();
        sample();
        checks++; if ({irsp_valid, drsp_valid, dreq_ready} !== 3'b100) begin errors++; $display("[TB] FAIL raw_ibeat got=%b exp=100", {irsp_valid, drsp_valid, dreq_ready}); end
        next_cycle();
        r_valid = 0; r_last = 0;
        for (int b = 0; b < 2; b++) begin
            dw_data_valid = 1; dw_data = $urandom(); dw_strb = 4'hF; w_ready = 1;
            sample();
            checks++; if (w_last !== (b == 1) || dreq_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_wbeat%0d got=%b exp=%b0", b, {w_last, dreq_ready}, b == 1); end
            next_cycle();
        end
        dw_data_valid = 0; w_ready = 0; b_valid = 1; b_resp = 2'b01;
        sample();
        checks++; if ({dw_done, dw_err, dreq_ready} !== 3'b100) begin errors++; $display("[TB] FAIL raw_bresp got=%b exp=100", {dw_done, dw_err, dreq_ready}); end
        next_cycle();
        b_valid = 0; b_resp = 0;
        sample();
        checks++; if (dreq_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_dreq_release got=%0b exp=1", dreq_ready); end
        model_last_d = 1'b1;
        next_cycle();
        dreq_valid = 0;
        dw_valid = 1; dw_addr = $urandom(); dw_len = 0;
        sample();
        checks++; if (dw_ready !== 1'b1 || ar_valid !== 1'b1) begin errors++; $display("[TB] FAIL raw_write_during_dread got=%b exp=11", {dw_ready, ar_valid}); end
        ar_ready = 1;
        next_cycle();
        dw_valid = 0; ar_ready = 0; aw_ready = 1;
        r_valid = 1; r_last = 1; r_data = $urandom();
        sample();
        checks++; if ({drsp_valid, aw_valid} !== 2'b11) begin errors++; $display("[TB] FAIL raw_dbeat_aw got=%b exp=11", {drsp_valid, aw_valid}); end
        next_cycle();
        aw_ready = 0; r_valid = 0; r_last = 0;
        dw_data_valid = 1; w_ready = 1;
        sample();
        checks++; if ({w_valid, w_last} !== 2'b11) begin errors++; $display("[TB] FAIL raw_single_w got=%b exp=11", {w_valid, w_last}); end
        next_cycle();
        dw_data_valid = 0; w_ready = 0; b_valid = 1;
        sample();
        checks++; if (dw_done !== 1'b1) begin errors++; $display("[TB] FAIL raw_second_done got=%0b exp=1", dw_done); end
        next_cycle();
        b_valid = 0;
    endtask

    task automatic test_ar_stall();
        logic [31:0] ia;
        logic [7:0] len;
        ia = $urandom(); len = 8'($urandom_range(1, 4));
        ireq_valid = 1; ireq_addr = ia; ireq_len = len;
        sample();
        checks++; if (ireq_ready !== 1'b1) begin errors++; $display("[TB] FAIL st_ireq_ready got=%0b exp=1", ireq_ready); end
        model_last_d = 1'b0;
        next_cycle();
        ireq_valid = 0;
        for (int s = 0; s < 5; s++) begin
            ireq_addr = $urandom(); ireq_len = 8'($urandom());
            sample();
            checks++; if (ar_valid !== 1'b1 || ar_addr !== ia || ar_len !== len || r_ready !== 1'b0) begin errors++; $display("[TB] FAIL st_hold s=%0d got=%0b/%h/%0d exp=1/%h/%0d", s, ar_valid, ar_addr, ar_len, ia, len); end
            next_cycle();
        end
        ar_ready = 1;
        next_cycle();
        ar_ready = 0;
        for (int b = 0; b <= int'(len); b++) begin
            r_valid = 1; r_data = $urandom(); r_last = (b == int'(len));
            sample();
            checks++; if (irsp_valid !== 1'b1 || irsp_last !== (b == int'(len))) begin errors++; $display("[TB] FAIL st_beat%0d got=%b exp=1%0b", b, {irsp_valid, irsp_last}, b == int'(len)); end
            next_cycle();
        end
        r_valid = 0; r_last = 0;
        sample();
        checks++; if (r_ready !== 1'b0) begin errors++; $display("[TB] FAIL st_done got=%0b exp=0", r_ready); end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] ia;
        ia = $urandom();
        ireq_valid = 1; ireq_addr = $urandom(); ireq_len = 8'd3;
        dw_valid = 1; dw_addr = $urandom(); dw_len = 0; dw_size = 3'd2;
        sample();
        checks++; if ({ireq_ready, dw_ready} !== 2'b11) begin errors++; $display("[TB] FAIL mr_accept got=%b exp=11", {ireq_ready, dw_ready}); end
        next_cycle();
        ireq_valid = 0; dw_valid = 0; ar_ready = 1; aw_ready = 1;
        next_cycle();
        ar_ready = 0; aw_ready = 0;
        r_valid = 1; r_last = 0; r_data = $urandom();
        dw_data_valid = 1; w_ready = 1;
        sample();
        checks++; if ({irsp_valid, w_last} !== 2'b11) begin errors++; $display("[TB] FAIL mr_beat1 got=%b exp=11", {irsp_valid, w_last}); end
        next_cycle();
        dw_data_valid = 0; w_ready = 0;
        r_valid = 1; r_data = $urandom();
        #1;
        checks++; if ({irsp_valid, b_ready} !== 2'b11) begin errors++; $display("[TB] FAIL mr_beat2_pre got=%b exp=11", {irsp_valid, b_ready}); end
        rst_n = 1'b0;
        b_valid = 1;
        sample();
        checks++; if ({r_ready, ar_valid, irsp_valid} !== 3'b000) begin errors++; $display("[TB] FAIL mr_read_drop got=%b exp=000", {r_ready, ar_valid, irsp_valid}); end
        checks++; if ({b_ready, dw_done} !== 2'b00) begin errors++; $display("[TB] FAIL mr_write_drop got=%b exp=00", {b_ready, dw_done}); end
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        model_last_d = 1'b0;
        ireq_valid = 1; ireq_addr = ia; ireq_len = 0;
        sample();
        checks++; if (ireq_ready !== 1'b1) begin errors++; $display("[TB] FAIL mr_regrant got=%0b exp=1", ireq_ready); end
        next_cycle();
        ireq_valid = 0;
        sample();
        checks++; if (ar_valid !== 1'b1 || ar_addr !== ia || ar_len !== 8'd0) begin errors++; $display("[TB] FAIL mr_ar got=%0b/%h/%0d exp=1/%h/0", ar_valid, ar_addr, ar_len, ia); end
        ar_ready = 1;
        next_cycle();
        ar_ready = 0; r_valid = 1; r_last = 1; r_data = $urandom();
        sample();
        checks++; if ({irsp_valid, irsp_last, dw_done} !== 3'b110) begin errors++; $display("[TB] FAIL mr_final_beat got=%b exp=110", {irsp_valid, irsp_last, dw_done}); end
        next_cycle();
        r_valid = 0; r_last = 0;
        sample();
        checks++; if (r_ready !== 1'b0) begin errors++; $display("[TB] FAIL mr_idle got=%0b exp=0", r_ready); end
    endtask

    initial begin
        test_reset();
        test_single_iread();
        test_round_robin();
        test_write_burst();
        test_simultaneous();
        test_raw_block();
        test_ar_stall();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
